id_pipe_stage: RTL and testbench
================================

Name: id_pipe_stage

Overview:
Parametrised instruction-decode stage. It contains:
- a register bank of configurable width and depth, with write-back bypass;
- an immediate extender with sign and zero modes;
- load-use hazard detection;
- a valid/ready ID/EX pipeline register with stall, bubble and flush.

It sits between the fetch stage and the execute stage. The external unit_control decodes if_instr[31:24] combinationally and drives the uc_* inputs. Instruction fields are fixed: WC=[23:20], RA=[19:16], RB=[15:12], IMM=[15:0].

Parameters:
DATA_W, 32, datapath/register width (must be >=16)
REG_AW, 4, register address width; register count = 2**REG_AW (field bits above REG_AW-1 ignored)
CTL_W, 16, width of the control word passed from unit_control to execute
ZERO_R0, 1, 1 = register 0 reads as zero and ignores writes
STALL_CNT_W, 16, width of saturating hazard-stall counter

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  synchronous, active-high reset
if_valid  in  1  fetch presents an instruction
if_ready  out  1  decode accepts the instruction this cycle
if_instr  in  32  instruction word
if_pc  in  DATA_W  PC of the instruction
uc_ctl  in  CTL_W  control word from unit_control
uc_op_se  in  1  1 = sign-extend IMM, 0 = zero-extend
uc_w_rb  in  1  instruction writes register WC
uc_rd_mem  in  1  instruction is a load (result available late)
uc_use_ra  in  1  instruction reads RA
uc_use_rb  in  1  instruction reads RB
wb_we  in  1  write-back enable
wb_addr  in  REG_AW  write-back register
wb_data  in  DATA_W  write-back data
flush  in  1  kill decode slot and ID/EX register
ex_ready  in  1  execute accepts ID/EX contents
ex_valid  out  1  ID/EX register holds a valid instruction
ex_ctl  out  CTL_W  registered control word
ex_pc  out  DATA_W  registered PC
ex_pra  out  DATA_W  registered operand A
ex_prb  out  DATA_W  registered operand B
ex_imm  out  DATA_W  registered extended immediate
ex_wc  out  REG_AW  registered destination register
ex_w_rb  out  1  registered write flag
ex_rd_mem  out  1  registered load flag
stall_cnt  out  STALL_CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset (synchronous, 1 cycle):
  - All ex_* outputs, ex_valid and stall_cnt go to 0.
  - All registers in the bank clear to 0.
  - wb writes are ignored while RESET=1.
  - if_ready=0 while RESET=1.
- Register bank:
  - Written on the rising CLK edge when wb_we=1.
  - When ZERO_R0=1, writes to address 0 are dropped and reads of address 0 return 0.
- Read bypass: if wb_we=1 and wb_addr==RA (and the address is not 0 when ZERO_R0=1), operand A = wb_data in the same cycle. The same rule applies to RB.
- Immediate: sign-extended or zero-extended to DATA_W according to uc_op_se.
- advance = !ex_valid | ex_ready.
- hazard = if_valid & ex_valid & ex_rd_mem & ex_w_rb & ((uc_use_ra & ex_wc==RA) | (uc_use_rb & ex_wc==RB)). Destination 0 is excluded when ZERO_R0=1.
- if_ready = !RESET & (flush | (advance & !hazard)).
- Per-cycle priority (highest first):
  1. flush: ex_valid<=0; the decode slot is consumed and dropped; other ex_* are don't-care.
  2. !advance: all ex_* hold.
  3. hazard: bubble (ex_valid<=0); ex_* data hold; the instruction stays at fetch.
  4. if_valid: load the ID/EX register with decoded values; ex_valid<=1.
  5. Otherwise: ex_valid<=0.
- Latency: one cycle from acceptance to ex_valid.
- A load followed by a dependent instruction costs exactly one bubble. The following cycle gets its operand through the wb bypass or the bank.
- stall_cnt increments on every cycle with hazard=1 and flush=0. It saturates at all-ones and never wraps.
- Simultaneous wb write and hazard: the write always completes.
- Flush during stall: flush wins, so ex_valid=0 next cycle regardless of ex_ready.

Test Plan:
- Reset, then write R3=0x12345678 via wb, then decode an instruction with RA=3, RB=0 -> ex_pra=0x12345678 and ex_prb=0 one cycle after acceptance.
- Bypass: wb_we=1, wb_addr=5, wb_data=0xCAFEF00D in the same cycle an instruction with RB=5 is accepted -> ex_prb=0xCAFEF00D.
- Immediate: IMM=0x8001 with uc_op_se=1 -> ex_imm=0xFFFF8001; with uc_op_se=0 -> ex_imm=0x00008001.
- Load-use: a load with WC=7 is in EX, and the next instruction has RA=7 with uc_use_ra=1 -> if_ready=0 for 1 cycle, ex_valid=0 (bubble), stall_cnt 0->1, then the instruction is accepted. The same sequence with WC=0 and ZERO_R0=1 gives no stall.
- Backpressure: ex_valid=1 and ex_ready=0 for 3 cycles -> all ex_* stable and if_ready=0. On ex_ready=1 the next instruction loads in one cycle.
- Flush: assert flush while stalled with ex_ready=0 -> ex_valid=0 next cycle and if_ready=1 during flush. Assert RESET mid-stream -> ex_valid=0, stall_cnt=0, and R3 reads 0.

Source files
------------

// File: rtl/id_pipe_stage.sv
// id_pipe_stage: instruction-decode stage.
//   Reads operands from a register bank, with write-back forwarding.
//   Extends the 16-bit immediate.
//   Detects load-use hazards.
//   Holds the result in a valid/ready ID/EX register with stall, bubble and flush.
// Ports:
//   CLK, RESET          rising-edge clock, synchronous active-high reset
//   if_*                fetch handshake (if_valid/if_ready), instruction word and PC
//   uc_*                control from the external unit_control for the instruction at fetch
//   wb_*                register write-back port
//   flush               kills the decode slot and the ID/EX register
//   ex_ready / ex_*     ID/EX register contents and handshake toward execute
//   stall_cnt           saturating count of load-use stall cycles
// Instruction fields: WC=[23:20], RA=[19:16], RB=[15:12], IMM=[15:0].
// Only REG_AW <= 4 is meaningful, because the register fields are 4 bits wide.
module id_pipe_stage #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 4,
  parameter int CTL_W       = 16,
  parameter int ZERO_R0     = 1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   if_valid,
  output logic                   if_ready,
  input  logic [31:0]            if_instr,
  input  logic [DATA_W-1:0]      if_pc,
  input  logic [CTL_W-1:0]       uc_ctl,
  input  logic                   uc_op_se,
  input  logic                   uc_w_rb,
  input  logic                   uc_rd_mem,
  input  logic                   uc_use_ra,
  input  logic                   uc_use_rb,
  input  logic                   wb_we,
  input  logic [REG_AW-1:0]      wb_addr,
  input  logic [DATA_W-1:0]      wb_data,
  input  logic                   flush,
  input  logic                   ex_ready,
  output logic                   ex_valid,
  output logic [CTL_W-1:0]       ex_ctl,
  output logic [DATA_W-1:0]      ex_pc,
  output logic [DATA_W-1:0]      ex_pra,
  output logic [DATA_W-1:0]      ex_prb,
  output logic [DATA_W-1:0]      ex_imm,
  output logic [REG_AW-1:0]      ex_wc,
  output logic                   ex_w_rb,
  output logic                   ex_rd_mem,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int NREG = 1 << REG_AW;

  logic [REG_AW-1:0] wc, ra, rb;
  assign wc = if_instr[20 +: REG_AW];
  assign ra = if_instr[16 +: REG_AW];
  assign rb = if_instr[12 +: REG_AW];

  // The opcode byte is decoded outside this block.
  logic unused_opcode;
  assign unused_opcode = ^if_instr[31:24];

  // Address 0 is hardwired to zero when ZERO_R0 is set.
  function automatic logic is_zero_reg(input logic [REG_AW-1:0] a);
    return (ZERO_R0 != 0) && (a == '0);
  endfunction

  // Register bank
  logic [DATA_W-1:0] rf [NREG];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_we && !is_zero_reg(wb_addr)) begin
      rf[wb_addr] <= wb_data;
    end
  end

  // Operand read. A write in this cycle overrides the bank; the zero register overrides both.
  logic [DATA_W-1:0] opa, opb;
  always_comb begin
    opa = rf[ra];
    opb = rf[rb];
    if (wb_we && wb_addr == ra) opa = wb_data;
    if (wb_we && wb_addr == rb) opb = wb_data;
    if (is_zero_reg(ra)) opa = '0;
    if (is_zero_reg(rb)) opb = '0;
  end

  // Immediate extension. The signed cast also covers DATA_W == 16.
  logic [DATA_W-1:0] imm;
  assign imm = uc_op_se ? DATA_W'($signed(if_instr[15:0])) : DATA_W'(if_instr[15:0]);

  // Hazard and handshake
  logic advance, hazard, dep;
  assign advance = !ex_valid || ex_ready;
  assign dep     = (uc_use_ra && ex_wc == ra) || (uc_use_rb && ex_wc == rb);
  assign hazard  = if_valid && ex_valid && ex_rd_mem && ex_w_rb && !is_zero_reg(ex_wc) && dep;
  assign if_ready = !RESET && (flush || (advance && !hazard));

  // ID/EX register. The data fields are left untouched on flush and bubble;
  // only the valid bit is cleared.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ex_valid  <= 1'b0;
      ex_ctl    <= '0;
      ex_pc     <= '0;
      ex_pra    <= '0;
      ex_prb    <= '0;
      ex_imm    <= '0;
      ex_wc     <= '0;
      ex_w_rb   <= 1'b0;
      ex_rd_mem <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (!advance) begin
      ex_valid <= ex_valid;
    end else if (hazard) begin
      ex_valid <= 1'b0;
    end else if (if_valid) begin
      ex_valid  <= 1'b1;
      ex_ctl    <= uc_ctl;
      ex_pc     <= if_pc;
      ex_pra    <= opa;
      ex_prb    <= opb;
      ex_imm    <= imm;
      ex_wc     <= wc;
      ex_w_rb   <= uc_w_rb;
      ex_rd_mem <= uc_rd_mem;
    end else begin
      ex_valid <= 1'b0;
    end
  end

  // Stall counter. It also counts hazard cycles while execute back-pressures,
  // and it holds at all-ones.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      stall_cnt <= '0;
    end else if (hazard && !flush && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_pipe_stage.sv
module tb_id_pipe_stage;
  logic        CLK = 0, RESET;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;
  logic [15:0] uc_ctl;
  logic        uc_op_se, uc_w_rb, uc_rd_mem, uc_use_ra, uc_use_rb;
  logic        wb_we;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush, ex_ready, ex_valid;
  logic [15:0] ex_ctl;
  logic [31:0] ex_pc, ex_pra, ex_prb, ex_imm;
  logic [3:0]  ex_wc;
  logic        ex_w_rb, ex_rd_mem;
  logic [15:0] stall_cnt;

  // Second instance: 2-bit stall counter, with register 0 an ordinary register
  logic        s_if_ready, s_ex_valid, s_ex_w_rb, s_ex_rd_mem;
  logic [15:0] s_ex_ctl;
  logic [31:0] s_ex_pc, s_ex_pra, s_ex_prb, s_ex_imm;
  logic [3:0]  s_ex_wc;
  logic [1:0]  s_stall_cnt;

  int checks = 0, failures = 0;

  always #5 CLK = ~CLK;

  id_pipe_stage dut (
    .CLK(CLK), .RESET(RESET), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .uc_ctl(uc_ctl), .uc_op_se(uc_op_se),
    .uc_w_rb(uc_w_rb), .uc_rd_mem(uc_rd_mem), .uc_use_ra(uc_use_ra), .uc_use_rb(uc_use_rb),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_ctl(ex_ctl), .ex_pc(ex_pc), .ex_pra(ex_pra), .ex_prb(ex_prb),
    .ex_imm(ex_imm), .ex_wc(ex_wc), .ex_w_rb(ex_w_rb), .ex_rd_mem(ex_rd_mem),
    .stall_cnt(stall_cnt));

  id_pipe_stage #(.ZERO_R0(0), .STALL_CNT_W(2)) u_sat (
    .CLK(CLK), .RESET(RESET), .if_valid(if_valid), .if_ready(s_if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .uc_ctl(uc_ctl), .uc_op_se(uc_op_se),
    .uc_w_rb(uc_w_rb), .uc_rd_mem(uc_rd_mem), .uc_use_ra(uc_use_ra), .uc_use_rb(uc_use_rb),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush), .ex_ready(ex_ready),
    .ex_valid(s_ex_valid), .ex_ctl(s_ex_ctl), .ex_pc(s_ex_pc), .ex_pra(s_ex_pra),
    .ex_prb(s_ex_prb), .ex_imm(s_ex_imm), .ex_wc(s_ex_wc), .ex_w_rb(s_ex_w_rb),
    .ex_rd_mem(s_ex_rd_mem), .stall_cnt(s_stall_cnt));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    RESET = 0; if_valid = 0; if_instr = 0; if_pc = 0; uc_ctl = 0; uc_op_se = 0;
    uc_w_rb = 0; uc_rd_mem = 0; uc_use_ra = 0; uc_use_rb = 0; wb_we = 0;
    wb_addr = 0; wb_data = 0; flush = 0; ex_ready = 1;
  endtask

  function automatic logic [31:0] mk(input logic [7:0] op, input logic [3:0] w,
                                     input logic [3:0] a, input logic [3:0] b,
                                     input logic [11:0] lo);
    return {op, w, a, b, lo};
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic        se, we;
    logic [3:0]  wa;
    logic [31:0] wd, pra, prb, imm;
  } vec_t;
  vec_t tbl[7];

  // Reference model state
  logic [31:0] mreg [16];
  logic        mv, mrd, mw;
  logic [31:0] mpc, mpa, mpb, mimm;
  logic [15:0] mctl, mstall;
  logic [3:0]  mwc;

  function automatic logic [31:0] mread(input logic [3:0] a);
    if (a == 0) return 0;
    if (wb_we && wb_addr == a) return wb_data;
    return mreg[a];
  endfunction

  initial begin
    logic [15:0] s0;
    logic        haz, adv, xr;
    logic [3:0]  fa, fb;
    logic [31:0] na, nb;

    tbl[0] = '{mk(8'h10, 4'd1, 4'd3, 4'd0, 12'h000), 1'b0, 1'b0, 4'd0, 32'h0,
               32'h12345678, 32'h0, 32'h00000000};
    tbl[1] = '{mk(8'h11, 4'd2, 4'd0, 4'd5, 12'h000), 1'b0, 1'b1, 4'd5, 32'hCAFEF00D,
               32'h0, 32'hCAFEF00D, 32'h00005000};
    tbl[2] = '{mk(8'h12, 4'd2, 4'd1, 4'd8, 12'h001), 1'b1, 1'b0, 4'd0, 32'h0,
               32'h0, 32'h0, 32'hFFFF8001};
    tbl[3] = '{mk(8'h12, 4'd2, 4'd1, 4'd8, 12'h001), 1'b0, 1'b0, 4'd0, 32'h0,
               32'h0, 32'h0, 32'h00008001};
    tbl[4] = '{mk(8'h13, 4'd0, 4'd5, 4'd3, 12'h000), 1'b1, 1'b0, 4'd0, 32'h0,
               32'hCAFEF00D, 32'h12345678, 32'h00003000};
    tbl[5] = '{mk(8'h14, 4'd0, 4'd0, 4'd9, 12'hFFF), 1'b1, 1'b1, 4'd0, 32'hDEADBEEF,
               32'h0, 32'h0, 32'hFFFF9FFF};
    tbl[6] = '{mk(8'h15, 4'd6, 4'd0, 4'd0, 12'h7FF), 1'b1, 1'b0, 4'd0, 32'h0,
               32'h0, 32'h0, 32'h000007FF};

    // Reset
    idle(); RESET = 1; #1;
    chk("rst_if_ready", if_ready, 0);
    step(); step();
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_stall", stall_cnt, 0);
    RESET = 0;

    // Write R3 through the write-back port
    wb_we = 1; wb_addr = 3; wb_data = 32'h12345678;
    step(); idle();

    // Table-driven decode vectors
    for (int i = 0; i < 7; i++) begin
      if_valid = 1; if_instr = tbl[i].instr; uc_op_se = tbl[i].se;
      uc_use_ra = 1; uc_use_rb = 1; uc_w_rb = 1; uc_rd_mem = 0;
      if_pc = 32'h100 + 32'(i * 4); uc_ctl = 16'h1000 + 16'(i);
      wb_we = tbl[i].we; wb_addr = tbl[i].wa; wb_data = tbl[i].wd;
      step();
      chk($sformatf("v%0d_valid", i), ex_valid, 1);
      chk($sformatf("v%0d_pra", i), ex_pra, tbl[i].pra);
      chk($sformatf("v%0d_prb", i), ex_prb, tbl[i].prb);
      chk($sformatf("v%0d_imm", i), ex_imm, tbl[i].imm);
      chk($sformatf("v%0d_pc", i), ex_pc, 32'h100 + 32'(i * 4));
      chk($sformatf("v%0d_ctl", i), ex_ctl, 16'h1000 + 16'(i));
      chk($sformatf("v%0d_wc", i), ex_wc, tbl[i].instr[23:20]);
    end
    idle(); step();

    // Load-use: a load writing R7, followed by an instruction reading R7
    if_valid = 1; if_instr = mk(8'h20, 4'd7, 4'd1, 4'd2, 12'h0); uc_rd_mem = 1; uc_w_rb = 1;
    if_pc = 32'h400;
    step();
    chk("lu_load_valid", ex_valid, 1);
    chk("lu_load_rd", ex_rd_mem, 1);
    if_instr = mk(8'h01, 4'd4, 4'd7, 4'd0, 12'h0); uc_rd_mem = 0; uc_use_ra = 1;
    if_pc = 32'h404;
    wb_we = 1; wb_addr = 7; wb_data = 32'hA5A50001;
    #1;
    chk("lu_if_ready_stall", if_ready, 0);
    step();
    chk("lu_bubble", ex_valid, 0);
    chk("lu_stall_cnt", stall_cnt, 1);
    wb_we = 0; #1;
    chk("lu_if_ready_after", if_ready, 1);
    step();
    chk("lu_accept_valid", ex_valid, 1);
    chk("lu_accept_pra", ex_pra, 32'hA5A50001);

    // Load to R0: no stall while R0 is hardwired to zero
    if_instr = mk(8'h20, 4'd0, 4'd1, 4'd2, 12'h0); uc_rd_mem = 1; uc_use_ra = 0;
    if_pc = 32'h408;
    step();
    if_instr = mk(8'h01, 4'd4, 4'd0, 4'd0, 12'h0); uc_rd_mem = 0; uc_use_ra = 1;
    if_pc = 32'h40C;
    #1;
    chk("z0_if_ready", if_ready, 1);
    chk("z0_sat_if_ready", s_if_ready, 0);
    step();
    chk("z0_valid", ex_valid, 1);
    chk("z0_stall_cnt", stall_cnt, 1);

    // Backpressure: execute holds ex_ready low for 3 cycles
    ex_ready = 0; uc_use_ra = 0; if_instr = mk(8'h02, 4'd5, 4'd1, 4'd1, 12'h0); if_pc = 32'h500;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp%0d_if_ready", c), if_ready, 0);
      step();
      chk($sformatf("bp%0d_valid", c), ex_valid, 1);
      chk($sformatf("bp%0d_pc", c), ex_pc, 32'h40C);
    end
    ex_ready = 1; #1;
    chk("bp_release_ready", if_ready, 1);
    step();
    chk("bp_next_pc", ex_pc, 32'h500);
    chk("bp_next_valid", ex_valid, 1);

    // Flush while execute is stalled
    ex_ready = 0; flush = 1; #1;
    chk("fl_if_ready", if_ready, 1);
    step();
    chk("fl_valid", ex_valid, 0);
    flush = 0;

    // Reset in the middle of the stream; the write in the same cycle is dropped
    ex_ready = 1; RESET = 1; wb_we = 1; wb_addr = 3; wb_data = 32'hFFFFFFFF;
    step();
    chk("mr_valid", ex_valid, 0);
    chk("mr_stall", stall_cnt, 0);
    RESET = 0; wb_we = 0;
    if_instr = mk(8'h03, 4'd1, 4'd3, 4'd3, 12'h0); uc_use_ra = 1; uc_use_rb = 1;
    step();
    chk("mr_r3_pra", ex_pra, 0);
    chk("mr_r3_prb", ex_prb, 0);

    // Sustained hazard under backpressure; the 2-bit counter must saturate
    RESET = 1; step(); RESET = 0;
    if_instr = mk(8'h20, 4'd7, 4'd1, 4'd2, 12'h0); uc_rd_mem = 1; uc_w_rb = 1;
    uc_use_ra = 0; uc_use_rb = 0;
    step();
    ex_ready = 0; uc_rd_mem = 0; uc_use_ra = 1; if_instr = mk(8'h01, 4'd4, 4'd7, 4'd0, 12'h0);
    #1;
    chk("sat_if_ready", if_ready, 0);
    for (int c = 0; c < 5; c++) step();
    chk("sat_main_cnt", stall_cnt, 5);
    chk("sat_small_cnt", s_stall_cnt, 3);
    flush = 1;
    step();
    chk("sat_flush_valid", ex_valid, 0);
    chk("sat_flush_nocount", stall_cnt, 5);
    idle();

    // Randomised run against the reference model
    RESET = 1; step(); RESET = 0;
    for (int i = 0; i < 16; i++) mreg[i] = 0;
    mv = 0; mrd = 0; mw = 0; mpc = 0; mpa = 0; mpb = 0; mimm = 0; mctl = 0; mwc = 0; mstall = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      RESET     = ($urandom_range(63) == 0);
      if_valid  = ($urandom_range(9) < 7);
      if_instr  = mk(8'($urandom), 4'($urandom_range(3)), 4'($urandom_range(3)),
                     4'($urandom_range(3)), 12'($urandom));
      if_pc     = $urandom;
      uc_ctl    = 16'($urandom);
      uc_op_se  = 1'($urandom);
      uc_w_rb   = ($urandom_range(9) < 7);
      uc_rd_mem = ($urandom_range(9) < 4);
      uc_use_ra = 1'($urandom);
      uc_use_rb = 1'($urandom);
      wb_we     = 1'($urandom);
      wb_addr   = 4'($urandom_range(3));
      wb_data   = $urandom;
      flush     = ($urandom_range(19) == 0);
      ex_ready  = ($urandom_range(9) < 6);
      #1;
      fa = if_instr[19:16];
      fb = if_instr[15:12];
      haz = if_valid && mv && mrd && mw && mwc != 0 &&
            ((uc_use_ra && mwc == fa) || (uc_use_rb && mwc == fb));
      adv = !mv || ex_ready;
      xr  = !RESET && (flush || (adv && !haz));
      chk("rnd_if_ready", if_ready, xr);
      na = mread(fa);
      nb = mread(fb);
      if (RESET) begin
        for (int i = 0; i < 16; i++) mreg[i] = 0;
        mv = 0; mrd = 0; mw = 0; mpc = 0; mpa = 0; mpb = 0; mimm = 0; mctl = 0; mwc = 0;
        mstall = 0;
      end else begin
        if (haz && !flush && mstall != 16'hFFFF) mstall = mstall + 1;
        if (flush) mv = 0;
        else if (!adv) mv = mv;
        else if (haz) mv = 0;
        else if (if_valid) begin
          mv = 1; mctl = uc_ctl; mpc = if_pc; mpa = na; mpb = nb; mwc = if_instr[23:20];
          mw = uc_w_rb; mrd = uc_rd_mem;
          mimm = uc_op_se ? {{16{if_instr[15]}}, if_instr[15:0]} : {16'h0, if_instr[15:0]};
        end else mv = 0;
        if (wb_we && wb_addr != 0) mreg[wb_addr] = wb_data;
      end
      step();
      chk("rnd_valid", ex_valid, mv);
      chk("rnd_stall", stall_cnt, mstall);
      if (mv) begin
        chk("rnd_ops", {ex_pra, ex_prb}, {mpa, mpb});
        chk("rnd_imm_pc", {ex_imm, ex_pc}, {mimm, mpc});
        chk("rnd_ctl", {ex_ctl, ex_wc, ex_w_rb, ex_rd_mem}, {42'h0, mctl, mwc, mw, mrd});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
